button_debouncer: RTL and testbench

Conditions a raw mechanical push-button input into a clean, debounced level plus single-cycle press/release strobes. It sits directly upstream of the LED blinker's reset/control path: on the MAX10 eval kit the user button drives btn_in, and btn_level or btn_press feeds the blinker's reset or enable. It contains its own 2-FF synchroniser, so btn_in may be fully asynchronous.

---
 rtl/button_debouncer.sv | 126 ++++++++++++
 tb/tb_button_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Turns a raw, bouncy, asynchronous push-button pin into a clean
//            pressed level plus one-cycle press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input  logic clk,
  input  logic rst_async,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_PIN = (ACTIVE_LOW_IN != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sync;
  logic             sync_pressed;
  logic             level_next, press_next, release_next;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      sync <= {2{IDLE_PIN}};
    end else begin
      sync <= {sync[0], btn_in};
    end
  end

  assign sync_pressed = sync[1] ^ IDLE_PIN;

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

  // Counter stops at CNT_LAST, where the state always changes, so it never wraps.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = btn_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      RELEASED: begin
        if (sync_pressed) begin
          state_next = CHECK_PRESS;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      CHECK_PRESS: begin
        if (!sync_pressed) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_pressed) begin
          state_next = CHECK_RELEASE;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      CHECK_RELEASE: begin
        if (sync_pressed) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = RELEASED;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed self-checking bench; instance 0 is active-low, 1 active-high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_async;
  logic btn   [2];
  logic level [2];
  logic press [2];
  logic rel   [2];

  int checks = 0;
  int errors = 0;
  int press_cnt [2] = '{0, 0};
  int rel_cnt   [2] = '{0, 0};
  int overlap = 0;
  int p0, r0;

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_IN(1)) dut_lo (
    .clk(clk), .rst_async(rst_async), .btn_in(btn[0]),
    .btn_level(level[0]), .btn_press(press[0]), .btn_release(rel[0])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_IN(0)) dut_hi (
    .clk(clk), .rst_async(rst_async), .btn_in(btn[1]),
    .btn_level(level[1]), .btn_press(press[1]), .btn_release(rel[1])
  );

  // Strobe census taken mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (press[i]) press_cnt[i]++;
      if (rel[i]) rel_cnt[i]++;
      if (press[i] && rel[i]) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive pin just after an edge; the next edge is edge 0, change lands after edge 5.
  task automatic apply_and_expect(input int idx, input logic pin, input logic exp_level,
                                  input string tag);
    btn[idx] = pin;
    repeat (5) tick();
    check({tag, "_hold"}, 32'(level[idx]), 32'(!exp_level));
    tick();
    check({tag, "_level"}, 32'(level[idx]), 32'(exp_level));
    check({tag, "_strobe"}, 32'(exp_level ? press[idx] : rel[idx]), 1);
    tick();
    check({tag, "_once"}, 32'({press[idx], rel[idx]}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst_async = 1'b0;
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    repeat (3) tick();
    check("rst_outs", 32'({level[0], press[0], rel[0]}), 0);

    // Button held through reset release
    rst_async = 1'b1;
    apply_and_expect(0, 1'b0, 1'b1, "rst_held");
    repeat (6) tick();
    check("rst_held_norel", 32'(rel_cnt[0]), 0);
    check("rst_held_level", 32'(level[0]), 1);

    // Clean release, press, release
    apply_and_expect(0, 1'b1, 1'b0, "clean_rel1");
    apply_and_expect(0, 1'b0, 1'b1, "clean_press");
    apply_and_expect(0, 1'b1, 1'b0, "clean_rel2");

    // Bounce: longest low run is 3 pin cycles
    p0 = press_cnt[0];
    r0 = rel_cnt[0];
    for (int r = 0; r < 6; r++) begin
      btn[0] = 1'b0; repeat (3) tick();
      btn[0] = 1'b1; tick();
      btn[0] = 1'b0; repeat (2) tick();
      btn[0] = 1'b1; tick();
    end
    repeat (3) tick();
    check("bounce_level", 32'(level[0]), 0);
    check("bounce_nostrobe", 32'((press_cnt[0] - p0) + (rel_cnt[0] - r0)), 0);
    btn[0] = 1'b0; repeat (6) tick();
    btn[0] = 1'b1; repeat (2) tick();
    check("bounce_accept_level", 32'(level[0]), 1);
    check("bounce_accept_press", 32'(press_cnt[0] - p0), 1);
    repeat (8) tick();
    check("bounce_after_rel", 32'(rel_cnt[0] - r0), 1);

    // Threshold: 3-cycle run rejected, 4-cycle run accepted
    p0 = press_cnt[0];
    btn[0] = 1'b0; repeat (3) tick();
    btn[0] = 1'b1; repeat (10) tick();
    check("thr3_level", 32'(level[0]), 0);
    check("thr3_press", 32'(press_cnt[0] - p0), 0);
    r0 = rel_cnt[0];
    btn[0] = 1'b0; repeat (4) tick();
    btn[0] = 1'b1; repeat (2) tick();
    check("thr4_level", 32'(level[0]), 1);
    check("thr4_press", 32'(press[0]), 1);
    repeat (8) tick();
    check("thr4_release", 32'(rel_cnt[0] - r0), 1);
    check("thr4_level_back", 32'(level[0]), 0);

    // Reset in CHECK_PRESS with count 2, then fresh debounce of held button
    btn[0] = 1'b0;
    repeat (4) tick();
    #2 rst_async = 1'b0;
    #1 check("rst_mid_outs", 32'({level[0], press[0], rel[0]}), 0);
    tick();
    rst_async = 1'b1;
    apply_and_expect(0, 1'b0, 1'b1, "rst_mid");

    // Async reset while PRESSED: level drops with no edge, no release strobe
    r0 = rel_cnt[0];
    #2 rst_async = 1'b0;
    #1 check("rst_pressed_level", 32'(level[0]), 0);
    btn[0] = 1'b1;
    repeat (3) tick();
    rst_async = 1'b1;
    repeat (10) tick();
    check("rst_pressed_norel", 32'(rel_cnt[0] - r0), 0);
    check("rst_pressed_level2", 32'(level[0]), 0);

    // Active-high instance: pin idle low through all resets above
    check("pol_idle_press", 32'(press_cnt[1]), 0);
    check("pol_idle_level", 32'(level[1]), 0);
    apply_and_expect(1, 1'b1, 1'b1, "pol_press");
    apply_and_expect(1, 1'b0, 1'b0, "pol_release");

    tick();
    check("strobe_overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
